// File: rtl/vga_dither_out.sv
// Output stage for a 2-bit-per-channel VGA renderer: optional ordered/temporal
// Bayer dithering down to 1 bit per channel, test bars, blanking, 2-cycle latency.
module vga_dither_out #(
  parameter int H_VIEW = 640,
  parameter int V_VIEW = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_n,
  input  logic       vsync_n,
  input  logic [5:0] rgb,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic [1:0] i_mode,
  output logic       o_hsync_n,
  output logic       o_vsync_n,
  output logic [5:0] o_rgb,
  output logic [2:0] o_rgb1,
  output logic [1:0] o_frame
);

  localparam logic [1:0]  MODE_PASS  = 2'd0;
  localparam logic [1:0]  MODE_TEMP  = 2'd2;
  localparam logic [1:0]  MODE_BARS  = 2'd3;
  localparam logic [10:0] H_LIM      = 11'(H_VIEW);
  localparam logic [10:0] V_LIM      = 11'(V_VIEW);

  logic [1:0] r_mode;
  logic [1:0] r_frame;

  logic       r_hs_p0, r_vs_p0;
  logic [5:0] r_rgb_p0;
  logic [2:0] r_rgb1_p0;

  logic       r_hs_p1, r_vs_p1;
  logic [5:0] r_rgb_p1;
  logic [2:0] r_rgb1_p1;

  logic       w_frame_evt;
  logic       w_visible;
  logic [1:0] w_t;
  logic [1:0] w_thr;
  logic [5:0] w_src;
  logic [2:0] w_d;
  logic [5:0] w_rgb;
  logic [2:0] w_rgb1;

  function automatic logic dith(input logic [1:0] c, input logic [1:0] thr);
    return (c == 2'd3) || (c > thr);
  endfunction

  // r_vs_p0 doubles as the stored previous vsync_n sample for edge detection
  assign w_frame_evt = r_vs_p0 & ~vsync_n;
  assign w_visible   = ({1'b0, hpos} < H_LIM) && ({1'b0, vpos} < V_LIM);

  always_comb begin
    w_t = 2'd0;
    unique case ({hpos[0], vpos[0]})
      2'b00: w_t = 2'd0;
      2'b11: w_t = 2'd1;
      2'b10: w_t = 2'd2;
      2'b01: w_t = 2'd3;
      default: w_t = 2'd0;
    endcase
    w_thr = (r_mode == MODE_TEMP) ? (w_t ^ r_frame) : w_t;
    w_src = (r_mode == MODE_BARS) ? {hpos[9], hpos[9], hpos[8], hpos[8], hpos[7], hpos[7]} : rgb;
    w_d   = {dith(rgb[5:4], w_thr), dith(rgb[3:2], w_thr), dith(rgb[1:0], w_thr)};
    if (r_mode == MODE_PASS || r_mode == MODE_BARS) begin
      w_rgb  = w_src;
      w_rgb1 = {w_src[5], w_src[3], w_src[1]};
    end else begin
      w_rgb  = {w_d[2], w_d[2], w_d[1], w_d[1], w_d[0], w_d[0]};
      w_rgb1 = w_d;
    end
    if (!w_visible) begin
      w_rgb  = 6'd0;
      w_rgb1 = 3'd0;
    end
  end

  // mode shadow and frame counter move together on the vsync falling edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode  <= MODE_PASS;
      r_frame <= 2'd0;
    end else if (w_frame_evt) begin
      r_mode  <= i_mode;
      r_frame <= r_frame + 2'd1;
    end
  end

  // stage 1: syncs and resolved colour
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs_p0   <= 1'b1;
      r_vs_p0   <= 1'b1;
      r_rgb_p0  <= 6'd0;
      r_rgb1_p0 <= 3'd0;
    end else begin
      r_hs_p0   <= hsync_n;
      r_vs_p0   <= vsync_n;
      r_rgb_p0  <= w_rgb;
      r_rgb1_p0 <= w_rgb1;
    end
  end

  // stage 2: output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs_p1   <= 1'b1;
      r_vs_p1   <= 1'b1;
      r_rgb_p1  <= 6'd0;
      r_rgb1_p1 <= 3'd0;
    end else begin
      r_hs_p1   <= r_hs_p0;
      r_vs_p1   <= r_vs_p0;
      r_rgb_p1  <= r_rgb_p0;
      r_rgb1_p1 <= r_rgb1_p0;
    end
  end

  assign o_hsync_n = r_hs_p1;
  assign o_vsync_n = r_vs_p1;
  assign o_rgb     = r_rgb_p1;
  assign o_rgb1    = r_rgb1_p1;
  assign o_frame   = r_frame;

endmodule

// File: tb/tb_vga_dither_out.sv
// Directed bench for vga_dither_out: reset, latency, dithering, temporal
// dithering, mode shadowing, bars, blanking and mid-frame reset.
module tb_vga_dither_out;

  logic       clk = 1'b0;
  logic       reset;
  logic       hsync_n, vsync_n;
  logic [5:0] rgb;
  logic [9:0] hpos, vpos;
  logic [1:0] i_mode;
  logic       o_hsync_n, o_vsync_n;
  logic [5:0] o_rgb;
  logic [2:0] o_rgb1;
  logic [1:0] o_frame;

  int n_total = 0;
  int n_bad   = 0;
  logic [1:0] exp_frame;

  always #5 clk = ~clk;

  vga_dither_out #(.H_VIEW(640), .V_VIEW(480)) dut (
    .clk(clk), .reset(reset), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .rgb(rgb), .hpos(hpos), .vpos(vpos), .i_mode(i_mode),
    .o_hsync_n(o_hsync_n), .o_vsync_n(o_vsync_n), .o_rgb(o_rgb),
    .o_rgb1(o_rgb1), .o_frame(o_frame)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one-cycle vsync_n low pulse: a single frame event
  task automatic vs_pulse();
    vsync_n = 1'b0;
    step();
    vsync_n = 1'b1;
    step();
    exp_frame = exp_frame + 2'd1;
  endtask

  logic [2:0] tmp_exp [4];
  logic       temp_d  [4];

  initial begin
    reset = 1'b1; hsync_n = 1'b1; vsync_n = 1'b1; rgb = 6'h3F;
    hpos = 10'd5; vpos = 10'd5; i_mode = 2'd0; exp_frame = 2'd0;
    step(); step(); step();
    chk("rst_hs",    {7'd0, o_hsync_n}, 8'd1);
    chk("rst_vs",    {7'd0, o_vsync_n}, 8'd1);
    chk("rst_rgb",   {2'd0, o_rgb},     8'd0);
    chk("rst_rgb1",  {5'd0, o_rgb1},    8'd0);
    chk("rst_frame", {6'd0, o_frame},   8'd0);

    // latency: first sample after reset reaches outputs after exactly 2 edges
    reset = 1'b0; rgb = 6'b10_01_11; hsync_n = 1'b0;
    step();
    rgb = 6'd0; hsync_n = 1'b1;
    chk("lat1_rgb", {2'd0, o_rgb}, 8'd0);
    chk("lat1_hs",  {7'd0, o_hsync_n}, 8'd1);
    step();
    chk("pass_rgb",  {2'd0, o_rgb},  8'b0010_0111);
    chk("pass_rgb1", {5'd0, o_rgb1}, 8'b101);
    chk("pass_hs",   {7'd0, o_hsync_n}, 8'd0);

    // ordered dither
    i_mode = 2'd1;
    vs_pulse();
    chk("frame_1", {6'd0, o_frame}, {6'd0, exp_frame});
    tmp_exp[0] = 3'b111; tmp_exp[1] = 3'b000; tmp_exp[2] = 3'b000; tmp_exp[3] = 3'b000;
    rgb = 6'b01_01_01;
    for (int k = 0; k < 4; k++) begin
      hpos = 10'(k & 1); vpos = 10'(k >> 1);
      step(); step();
      chk("ord_01", {5'd0, o_rgb1}, {5'd0, tmp_exp[k]});
    end
    hpos = 10'd0; vpos = 10'd0;
    step(); step();
    chk("ord_rgb_wide", {2'd0, o_rgb}, 8'h3F);
    rgb = 6'h3F;
    for (int k = 0; k < 4; k++) begin
      hpos = 10'(k & 1); vpos = 10'(k >> 1);
      step(); step();
      chk("ord_11", {5'd0, o_rgb1}, 8'b111);
    end

    // temporal dither at (1,1), rgb=2 per channel: threshold 1^frame
    temp_d[0] = 1'b1; temp_d[1] = 1'b1; temp_d[2] = 1'b0; temp_d[3] = 1'b0;
    i_mode = 2'd2;
    while (exp_frame != 2'd3) vs_pulse();
    rgb = 6'b10_10_10; hpos = 10'd1; vpos = 10'd1;
    vs_pulse();
    for (int k = 0; k < 5; k++) begin
      step(); step();
      chk("tmp_frame", {6'd0, o_frame}, {6'd0, exp_frame});
      chk("tmp_rgb1",  {5'd0, o_rgb1},  temp_d[exp_frame] ? 8'd7 : 8'd0);
      vs_pulse();
    end

    // mode shadow: i_mode change mid-frame has no effect until vsync falls
    i_mode = 2'd0;
    vs_pulse();
    i_mode = 2'd3; rgb = 6'b10_01_11; hpos = 10'd384; vpos = 10'd5;
    for (int k = 0; k < 4; k++) step();
    chk("shadow_hold", {2'd0, o_rgb}, 8'b0010_0111);
    vs_pulse();
    step(); step();
    chk("bars_rgb",  {2'd0, o_rgb},  8'b0000_1111);
    chk("bars_rgb1", {5'd0, o_rgb1}, 8'b011);

    // i_mode changing on the frame-event cycle itself is taken
    i_mode = 2'd0; vsync_n = 1'b0;
    step();
    vsync_n = 1'b1; exp_frame = exp_frame + 2'd1;
    step(); step();
    chk("evt_mode_rgb", {2'd0, o_rgb}, 8'b0010_0111);

    // blanking in mode 0 and mode 1
    rgb = 6'h3F; hpos = 10'd640; vpos = 10'd5; hsync_n = 1'b0;
    step(); step();
    chk("blank_h_rgb",  {2'd0, o_rgb},  8'd0);
    chk("blank_h_rgb1", {5'd0, o_rgb1}, 8'd0);
    chk("blank_h_hs",   {7'd0, o_hsync_n}, 8'd0);
    hsync_n = 1'b1; i_mode = 2'd1;
    vs_pulse();
    hpos = 10'd5; vpos = 10'd480;
    step(); step();
    chk("blank_v_rgb1", {5'd0, o_rgb1}, 8'd0);
    hpos = 10'd639; vpos = 10'd479;
    step(); step();
    chk("edge_vis_rgb1", {5'd0, o_rgb1}, 8'b111);

    // reset mid-frame with frame=2 and vsync low
    while (exp_frame != 2'd2) vs_pulse();
    chk("pre_rst_frame", {6'd0, o_frame}, 8'd2);
    vsync_n = 1'b0; reset = 1'b1;
    step();
    chk("mid_rst_frame", {6'd0, o_frame},   8'd0);
    chk("mid_rst_vs",    {7'd0, o_vsync_n}, 8'd1);
    chk("mid_rst_hs",    {7'd0, o_hsync_n}, 8'd1);
    reset = 1'b0; vsync_n = 1'b1; hsync_n = 1'b0; exp_frame = 2'd0;
    step();
    chk("post_rst_hs1", {7'd0, o_hsync_n}, 8'd1);
    chk("post_rst_vs1", {7'd0, o_vsync_n}, 8'd1);
    step();
    chk("post_rst_hs2", {7'd0, o_hsync_n}, 8'd0);
    step(); step();
    chk("post_rst_noinc", {6'd0, o_frame}, 8'd0);
    vsync_n = 1'b0;
    step();
    chk("post_rst_inc", {6'd0, o_frame}, 8'd1);
    vsync_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_dither_out.md
VGA_DITHER_OUT -- requirements
Module: vga_dither_out

Interface
REQ-001 SHALL have parameter H_VIEW, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_VIEW, default 480, visible lines per frame.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port hsync_n  input  1  active-low hsync from the renderer.
REQ-006 SHALL have port vsync_n  input  1  active-low vsync from the renderer.
REQ-007 SHALL have port rgb  input  6  renderer colour, {R[1:0],G[1:0],B[1:0]}.
REQ-008 SHALL have port hpos  input  10  renderer horizontal position.
REQ-009 SHALL have port vpos  input  10  renderer vertical position.
REQ-010 SHALL have port i_mode  input  2  requested mode: 0 pass, 1 ordered dither, 2 ordered+temporal, 3 test bars.
REQ-011 SHALL have port o_hsync_n  output  1  delayed hsync_n.
REQ-012 SHALL have port o_vsync_n  output  1  delayed vsync_n.
REQ-013 SHALL have port o_rgb  output  6  final 2-bit-per-channel colour.
REQ-014 SHALL have port o_rgb1  output  3  1-bit-per-channel colour {R,G,B}.
REQ-015 SHALL have port o_frame  output  2  frame counter.

Function
REQ-016 SHALL be a 2-stage pipeline: every input sample appears on o_hsync_n/o_vsync_n/o_rgb/o_rgb1 exactly 2 cycles later, sync and colour aligned.
REQ-017 SHALL force colour to 0 on both colour outputs when hpos>=H_VIEW or vpos>=V_VIEW, in every mode.
REQ-018 SHALL derive the Bayer threshold t from {hpos[0],vpos[0]}: (0,0)->0, (1,1)->1, (1,0)->2, (0,1)->3.
REQ-019 SHALL, in mode 2, use t XOR o_frame as the threshold; other modes use t unchanged.
REQ-020 SHALL compute each dithered channel bit d = (c==3) OR (c>threshold), with c the 2-bit channel value; c=0 always gives 0, and c=3 always gives 1.
REQ-021 SHALL, in mode 0, output o_rgb=rgb and o_rgb1={R[1],G[1],B[1]}.
REQ-022 SHALL, in modes 1/2, output o_rgb1={dR,dG,dB} and o_rgb={dR,dR,dG,dG,dB,dB}.
REQ-023 SHALL, in mode 3, replace rgb with {hpos[9],hpos[9],hpos[8],hpos[8],hpos[7],hpos[7]} and then apply mode-0 output rules.
REQ-024 SHALL detect the frame event as registered vsync_n transitioning 1->0 (previous sample 1, current sample 0).
REQ-025 SHALL increment o_frame by 1 modulo 4 on each frame event; 3 wraps to 0.
REQ-026 SHALL hold the active mode in a shadow register loaded from i_mode only on a frame event; i_mode changes at other times have no effect.
REQ-027 SHALL, when i_mode changes on the same cycle as a frame event, load that cycle's i_mode value; it governs samples entering stage 1 from the next cycle.
REQ-028 SHALL apply the frame counter and active mode atomically: both update on the same edge.
REQ-029 SHALL pass sync signals unchanged in value (only delayed) in all modes.

Reset
REQ-030 SHALL, while reset is high, drive o_hsync_n=1, o_vsync_n=1, o_rgb=0, o_rgb1=0, o_frame=0, active mode=0, and stored previous vsync_n=1.
REQ-031 SHALL clear all pipeline stages on reset, so the first post-reset input sample appears on the outputs 2 cycles after reset deasserts.
REQ-032 SHALL treat reset asserted mid-line or mid-frame identically to power-on reset, with no partial frame event generated.

Verification
REQ-033 SHALL pass this scenario: mode 0, rgb=6'b10_01_11 at hpos=5, vpos=5 -> o_rgb=6'b10_01_11 and o_rgb1=3'b101 exactly 2 cycles later.
REQ-034 SHALL pass this scenario: mode 1, rgb=6'b01_01_01 held over hpos 0..1, vpos 0..1 -> o_rgb1=3'b111 at (0,0) and 3'b000 at the other three positions; rgb=6'b11_11_11 -> 3'b111 at all four positions.
REQ-035 SHALL pass this scenario: mode 2, rgb=6'b10_10_10 at fixed (1,1) over 4 frames -> o_frame steps 0,1,2,3,0 and o_rgb1 follows (2>1),(2>0),(2>3),(2>2) = 1,1,0,0 per channel.
REQ-036 SHALL pass this scenario: i_mode set 0->3 mid-frame -> output unchanged until the next vsync_n falling edge; then at hpos=384, o_rgb=6'b00_11_11.
REQ-037 SHALL pass this scenario: hpos=640 with rgb=6'h3F in any mode -> o_rgb=0 and o_rgb1=0, while sync passes through with 2-cycle delay.
REQ-038 SHALL pass this scenario: reset pulsed for 1 cycle while o_frame=2 and vsync_n=0 -> o_frame=0, syncs high for 2 cycles, and no frame increment until the next 1->0 vsync_n transition.
